// File: rtl/harpoon_2.sv
// Player-2 harpoon: fires from the player's centre, climbs once per frame and
// retires on ceiling or ball contact. `STICKY_HARPOON_EN` adds a ceiling dwell.
module harpoon_2 #(
  parameter int ROPE_SPEED      = 4,
  parameter int CEILING_Y       = 10,
  parameter int FLOOR_Y         = 400,
  parameter int PLAYER_W        = 43,
  parameter int HARPOON_HW      = 1,
  parameter int COOLDOWN_FRAMES = 8
`ifdef STICKY_HARPOON_EN
  ,
  parameter int HOLD_FRAMES     = 30
`endif
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic [7:0] keycode4,
  input  logic [7:0] fire_key,
  input  logic [1:0] game_on,
  input  logic       player_2_inplay,
  input  logic [9:0] PlayerX,
  input  logic       ball_hit,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] harpoon_x,
  output logic [9:0] harpoon_top,
  output logic       harpoon_active,
  output logic       harpoon_on,
  output logic [7:0] shots_fired
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EXTEND   = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;
`ifdef STICKY_HARPOON_EN
  localparam logic [1:0] ST_HOLD     = 2'd3;
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_FRAMES - 1);
`endif

  localparam logic [9:0] FLOOR_ROW  = 10'(FLOOR_Y);
  localparam logic [9:0] CEIL_ROW   = 10'(CEILING_Y);
  localparam logic [9:0] STEP       = 10'(ROPE_SPEED);
  localparam logic [9:0] CEIL_THR   = 10'(CEILING_Y + ROPE_SPEED);
  localparam logic [9:0] LAUNCH_OFS = 10'((PLAYER_W + 1) / 2);
  localparam logic [9:0] HALF_W     = 10'(HARPOON_HW);
  localparam logic [7:0] COOL_LOAD  = 8'(COOLDOWN_FRAMES - 1);

  logic [1:0] state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] top_q, top_d;
  logic       active_q, active_d;
  logic [7:0] shots_q, shots_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fire_prev_q;

  logic       fire_now;
  logic       fire_edge;
  logic       play_ok;
  logic [7:0] shots_inc;
  logic [9:0] x_lo;
  logic [9:0] x_hi;

  assign fire_now  = (keycode  == fire_key) || (keycode2 == fire_key) ||
                     (keycode3 == fire_key) || (keycode4 == fire_key);
  assign fire_edge = fire_now & ~fire_prev_q;
  assign play_ok   = (game_on != 2'd0) && player_2_inplay;
  assign shots_inc = (shots_q == 8'hFF) ? shots_q : shots_q + 8'd1;

  // Next-state: the play-enable override wins over every state action.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    top_d    = top_q;
    active_d = active_q;
    shots_d  = shots_q;
    cnt_d    = cnt_q;
    if (!play_ok) begin
      state_d  = ST_IDLE;
      top_d    = FLOOR_ROW;
      active_d = 1'b0;
      cnt_d    = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fire_edge) begin
            state_d  = ST_EXTEND;
            x_d      = PlayerX + LAUNCH_OFS;
            top_d    = FLOOR_ROW - STEP;
            active_d = 1'b1;
            shots_d  = shots_inc;
          end else begin
            top_d    = FLOOR_ROW;
            active_d = 1'b0;
          end
        end
        ST_EXTEND: begin
          if (ball_hit) begin
            state_d  = ST_COOLDOWN;
            top_d    = FLOOR_ROW;
            active_d = 1'b0;
            cnt_d    = COOL_LOAD;
          end else if (top_q <= CEIL_THR) begin
            // The contact frame stays drawn at the ceiling before retiring.
            top_d    = CEIL_ROW;
            active_d = 1'b1;
`ifdef STICKY_HARPOON_EN
            state_d  = ST_HOLD;
            cnt_d    = HOLD_LOAD;
`else
            state_d  = ST_COOLDOWN;
            cnt_d    = COOL_LOAD;
`endif
          end else begin
            top_d    = top_q - STEP;
          end
        end
`ifdef STICKY_HARPOON_EN
        ST_HOLD: begin
          if (ball_hit || (cnt_q == 8'd0)) begin
            state_d  = ST_COOLDOWN;
            top_d    = FLOOR_ROW;
            active_d = 1'b0;
            cnt_d    = COOL_LOAD;
          end else begin
            cnt_d    = cnt_q - 8'd1;
          end
        end
`endif
        ST_COOLDOWN: begin
          top_d    = FLOOR_ROW;
          active_d = 1'b0;
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          top_d    = FLOOR_ROW;
          active_d = 1'b0;
          cnt_d    = 8'd0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      x_q         <= 10'd0;
      top_q       <= FLOOR_ROW;
      active_q    <= 1'b0;
      shots_q     <= 8'd0;
      cnt_q       <= 8'd0;
      fire_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      top_q       <= top_d;
      active_q    <= active_d;
      shots_q     <= shots_d;
      cnt_q       <= cnt_d;
      fire_prev_q <= fire_now;
    end
  end

  assign x_lo = x_q - HALF_W;
  assign x_hi = x_q + HALF_W;

  // Pixel hit test against the live geometry; the rope spans tip to floor.
  always_comb begin
    harpoon_on = active_q && (DrawX >= x_lo) && (DrawX <= x_hi) &&
                 (DrawY >= top_q) && (DrawY < FLOOR_ROW);
  end

  assign harpoon_x      = x_q;
  assign harpoon_top    = top_q;
  assign harpoon_active = active_q;
  assign shots_fired    = shots_q;

endmodule

// File: tb/tb_harpoon_2.sv
// Scoreboard bench for harpoon_2: per-frame expectations from a frame-count
// model are queued by the stimulus and checked by an independent monitor.
module tb_harpoon_2;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode, keycode2, keycode3, keycode4, fire_key;
  logic [1:0] game_on;
  logic       player_2_inplay;
  logic [9:0] PlayerX;
  logic       ball_hit;
  logic [9:0] DrawX, DrawY;
  logic [9:0] harpoon_x, harpoon_top;
  logic       harpoon_active, harpoon_on;
  logic [7:0] shots_fired;

  harpoon_2 dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .keycode(keycode), .keycode2(keycode2), .keycode3(keycode3), .keycode4(keycode4),
    .fire_key(fire_key), .game_on(game_on), .player_2_inplay(player_2_inplay),
    .PlayerX(PlayerX), .ball_hit(ball_hit), .DrawX(DrawX), .DrawY(DrawY),
    .harpoon_x(harpoon_x), .harpoon_top(harpoon_top), .harpoon_active(harpoon_active),
    .harpoon_on(harpoon_on), .shots_fired(shots_fired)
  );

  initial frame_clk = 1'b0;
  always #1000 frame_clk = ~frame_clk;

  typedef struct {
    int x;
    int top;
    int act;
    int shots;
    int on;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // staged inputs, applied at the next falling edge
  logic [7:0] s_k1, s_k2, s_k3, s_k4;
  logic [7:0] s_fk = 8'h1A;
  logic [1:0] s_gon = 2'd1;
  logic       s_inplay = 1'b1;
  logic       s_rst = 1'b1;
  logic       s_hit = 1'b0;
  int         s_px = 380;
  int         s_dx = 0;
  int         s_dy = 0;

  // reference model: geometry plus remaining-frame counters
  int m_x, m_top, m_shots, m_cool, m_hold;
  bit m_act, m_fly, m_prev;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_on(int dx, int dy);
    return (m_act && dx >= m_x - 1 && dx <= m_x + 1 && dy >= m_top && dy < 400) ? 1 : 0;
  endfunction

  function automatic logic [7:0] other_key();
    logic [7:0] k;
    k = 8'($urandom_range(0, 255));
    if (k == s_fk) k = k ^ 8'h01;
    return k;
  endfunction

  task automatic release_keys();
    s_k1 = other_key(); s_k2 = other_key(); s_k3 = other_key(); s_k4 = other_key();
  endtask

  task automatic frame();
    bit   pressed, fe;
    exp_t e;
    @(negedge frame_clk);
    Reset = s_rst; keycode = s_k1; keycode2 = s_k2; keycode3 = s_k3; keycode4 = s_k4;
    fire_key = s_fk; game_on = s_gon; player_2_inplay = s_inplay;
    PlayerX = 10'(s_px); ball_hit = s_hit; DrawX = 10'(s_dx); DrawY = 10'(s_dy);
    pressed = (s_k1 == s_fk) || (s_k2 == s_fk) || (s_k3 == s_fk) || (s_k4 == s_fk);
    if (s_rst) begin
      m_x = 0; m_top = 400; m_act = 0; m_shots = 0;
      m_fly = 0; m_cool = 0; m_hold = 0; m_prev = 0;
    end else begin
      fe = pressed && !m_prev;
      m_prev = pressed;
      if (s_gon == 2'd0 || !s_inplay) begin
        m_act = 0; m_top = 400; m_fly = 0; m_cool = 0; m_hold = 0;
      end else if (m_fly) begin
        if (s_hit) begin
          m_fly = 0; m_act = 0; m_top = 400; m_cool = 8;
        end else if (m_top - 4 <= 10) begin
          m_top = 10; m_fly = 0;
`ifdef STICKY_HARPOON_EN
          m_hold = 30;
`else
          m_cool = 8;
`endif
        end else begin
          m_top = m_top - 4;
        end
      end else if (m_hold > 0) begin
        if (s_hit || m_hold == 1) begin
          m_hold = 0; m_act = 0; m_top = 400; m_cool = 8;
        end else begin
          m_hold--;
        end
      end else if (m_cool > 0) begin
        m_cool--; m_act = 0; m_top = 400;
      end else if (fe) begin
        m_fly = 1; m_act = 1; m_x = (s_px + 22) % 1024; m_top = 396;
        if (m_shots < 255) m_shots++;
      end
    end
    e.x = m_x; e.top = m_top; e.act = m_act; e.shots = m_shots;
    e.on = exp_on(s_dx, s_dy);
    exp_q.push_back(e);
  endtask

  // sweep the pixel test around the column while geometry is steady
  task automatic probe();
    int ys[5] = '{199, 200, 300, 399, 400};
    @(posedge frame_clk);
    #2;
    for (int dx = 400; dx <= 404; dx++) begin
      for (int j = 0; j < 5; j++) begin
        DrawX = 10'(dx);
        DrawY = 10'(ys[j]);
        #1;
        check("harpoon_on_probe", int'(harpoon_on), exp_on(dx, ys[j]));
      end
    end
  endtask

  task automatic press1(int slot);
    release_keys();
    case (slot)
      0: s_k1 = s_fk;
      1: s_k2 = s_fk;
      2: s_k3 = s_fk;
      default: s_k4 = s_fk;
    endcase
  endtask

  // monitor: every frame presents a fresh output set
  always @(posedge frame_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("harpoon_x", int'(harpoon_x), mon_e.x);
      check("harpoon_top", int'(harpoon_top), mon_e.top);
      check("harpoon_active", int'(harpoon_active), mon_e.act);
      check("shots_fired", int'(shots_fired), mon_e.shots);
      check("harpoon_on", int'(harpoon_on), mon_e.on);
    end
  end

  initial begin
    Reset = 1'b1; keycode = 8'h00; keycode2 = 8'h00; keycode3 = 8'h00; keycode4 = 8'h00;
    fire_key = 8'h1A; game_on = 2'd1; player_2_inplay = 1'b1; PlayerX = 10'd380;
    ball_hit = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    release_keys();
    repeat (3) frame();
    s_rst = 1'b0;

    // fire held in keycode3 for 200 frames: one shot, full flight, cooldown
    press1(2);
    for (int i = 0; i < 200; i++) begin
      s_px = (i == 0) ? 380 : int'($urandom_range(10, 600));
      s_dx = 401; s_dy = int'($urandom_range(0, 479));
      frame();
      if (i == 49) probe();
    end
    release_keys();
    repeat (15) frame();

    // ball hit at tip 300, early refire ignored, late refire accepted
    s_px = 200; press1(0); frame();
    release_keys();
    for (int g = 0; g < 100 && m_top != 300; g++) frame();
    s_hit = 1'b1; frame(); s_hit = 1'b0;
    repeat (2) frame();
    press1(1); frame(); release_keys();
    repeat (5) frame();
    press1(3); frame(); release_keys();
    repeat (3) frame();
    s_hit = 1'b1; frame(); s_hit = 1'b0;
    repeat (12) frame();

    // play-enable overrides
    press1(0); frame(); release_keys();
    repeat (10) frame();
    s_gon = 2'd0; frame(); s_gon = 2'd2;
    repeat (2) frame();
    s_inplay = 1'b0; press1(2); frame(); release_keys(); frame();
    s_inplay = 1'b1;
    repeat (2) frame();

`ifdef STICKY_HARPOON_EN
    // ceiling dwell with a hit on the fifth hold frame
    press1(1); frame(); release_keys();
    for (int g = 0; g < 150 && m_hold == 0; g++) frame();
    repeat (4) frame();
    s_hit = 1'b1; frame(); s_hit = 1'b0;
    repeat (12) frame();
`endif

    // drive the shot counter past saturation
    for (int n = 0; n < 260; n++) begin
      s_px = int'($urandom_range(10, 600));
      press1(int'($urandom_range(0, 3))); frame();
      release_keys(); s_hit = 1'b1; frame(); s_hit = 1'b0;
      repeat (9) frame();
    end

    // randomized play
    for (int n = 0; n < 1500; n++) begin
      release_keys();
      if ($urandom_range(0, 2) == 0) press1(int'($urandom_range(0, 3)));
      s_hit    = ($urandom_range(0, 7) == 0);
      s_gon    = ($urandom_range(0, 39) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      s_inplay = ($urandom_range(0, 39) != 0);
      s_px     = int'($urandom_range(10, 600));
      s_dx     = m_x - 3 + int'($urandom_range(0, 6));
      s_dy     = int'($urandom_range(0, 479));
      frame();
    end

    @(posedge frame_clk);
    #5;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
